line_window_fetch: RTL and testbench
====================================

LINE_WINDOW_FETCH -- requirements
Module: line_window_fetch

Interface
REQ-001 Parameter WORD_W, default 32, width of input words and output window in bits.
REQ-002 Parameter LINE_WORDS, default 16, words per line; line width LINE_W = WORD_W*LINE_WORDS = 512.
REQ-003 sysclk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 wr_valid  input  1  upstream word valid.
REQ-006 wr_data  input  WORD_W  upstream word.
REQ-007 wr_ready  output  1  block accepts a word this cycle.
REQ-008 flush  input  1  discard the line and return to filling.
REQ-009 rd_valid  input  1  window request valid.
REQ-010 rd_offset  input  9  start bit of the requested window within the line.
REQ-011 rd_ready  output  1  block accepts a request this cycle.
REQ-012 win_valid  output  1  win_data/win_err valid; one-cycle pulse per request.
REQ-013 win_data  output  WORD_W  extracted window.
REQ-014 win_err  output  1  request was out of range (WRAP_EN absent only).
REQ-015 line_done  output  1  one-cycle pulse when the line becomes complete.

Function
REQ-016 Two states: FILL and SERVE; reset state FILL.
REQ-017 FILL: wr_ready=1, rd_ready=0; word accepted on wr_valid&wr_ready and stored at line bits [WORD_W*n+WORD_W-1 : WORD_W*n], n = 4-bit word count, which then increments.
REQ-018 Acceptance of word LINE_WORDS-1 moves the block to SERVE next cycle, clears the count and asserts line_done for exactly that next cycle.
REQ-019 SERVE: wr_ready=0, rd_ready=1; the line is held unchanged.
REQ-020 Request accepted on rd_valid&rd_ready; win_valid, win_data, win_err registered, presented exactly 1 cycle later, win_valid high for one cycle; back-to-back requests give back-to-back responses.
REQ-021 win_data bit b = line bit (rd_offset+b) for offsets 0..LINE_W-WORD_W (0..480).
REQ-022 flush in FILL clears the word count; flush in SERVE moves to FILL next cycle with count 0.
REQ-023 flush has priority over a same-cycle wr_valid or rd_valid: the word or request is dropped and no win_valid follows.
REQ-024 rd_valid in FILL and wr_valid in SERVE are ignored with no side effect.
REQ-025 When win_valid=0, win_data holds its last value and win_err=0.

Reset
REQ-026 Asserted reset (low) forces, asynchronously: state FILL, count 0, line storage 0, wr_ready=1, rd_ready=0, win_valid=0, win_data=0, win_err=0, line_done=0.
REQ-027 Reset mid-fill or mid-serve discards the partial or complete line; after release, a full LINE_WORDS words are required before SERVE.

Configuration
REQ-028 Macro LINE_WINDOW_WRAP_EN defined: offsets 481..511 wrap circularly, win_data bit b = line bit ((rd_offset+b) mod LINE_W), win_err always 0.
REQ-029 Macro LINE_WINDOW_WRAP_EN undefined: offsets 481..511 return win_data=0 and win_err=1 with normal win_valid timing.

Structure
REQ-030 Package line_window_pkg holds WORD_W, LINE_WORDS, LINE_W, offset width (9) and the FILL/SERVE state typedef.
REQ-031 A combinational sub-module line_window_slice (line, offset -> window, err) implements the extraction, including the wrap/err logic; line_window_fetch holds the state machine, counter, storage and output registers.

Verification
REQ-032 Fill words 0x1000_0000+i (i=0..15) -> line_done pulses one cycle after word 15, wr_ready=0, rd_ready=1.
REQ-033 In SERVE, request offset 0 then offset 16 back-to-back -> win_data 0x1000_0000 then 0x0001_1000 on consecutive cycles, each 1 cycle after its request, win_err=0.
REQ-034 Request offset 496 -> with LINE_WINDOW_WRAP_EN: win_data 0x0000_1000, win_err=0; without: win_data 0, win_err=1.
REQ-035 Reset asserted after 7 accepted words -> all outputs at reset values; after release, 15 words leave the block in FILL, and the 16th word produces line_done.
REQ-036 In SERVE, flush and rd_valid (offset 0) in the same cycle -> no win_valid, block returns to FILL with wr_ready=1 next cycle.

Source files
------------

// File: rtl/line_window_pkg.sv
// ---------------------------------------------------------------------------
// line_window_pkg
// Shared constants and types for the line window fetch block.
//   WORD_W     : width of one upstream word and of the extracted window
//   LINE_WORDS : number of words that make up one line
//   LINE_W     : total line width in bits
//   OFFSET_W   : width of the window start-bit offset
//   state_t    : FILL (collecting words) / SERVE (answering window requests)
// Optional feature macro: LINE_WINDOW_WRAP_EN (see line_window_slice).
// ---------------------------------------------------------------------------
package line_window_pkg;

    localparam int WORD_W     = 32;
    localparam int LINE_WORDS = 16;
    localparam int LINE_W     = WORD_W * LINE_WORDS;
    localparam int OFFSET_W   = 9;

    typedef enum logic {
        FILL  = 1'b0,
        SERVE = 1'b1
    } state_t;

endpackage

// File: rtl/line_window_slice.sv
// ---------------------------------------------------------------------------
// line_window_slice
// Purely combinational extraction of a WORD_W-bit window from a line.
// Ports:
//   line_i   : full line, word 0 in the least significant bits
//   offset_i : start bit of the window within the line
//   window_o : window_o[b] = line bit (offset_i + b)
//   err_o    : window would run past the end of the line
// Macro LINE_WINDOW_WRAP_EN:
//   defined   - windows running past the top of the line wrap to bit 0,
//               err_o is never raised
//   undefined - such windows return zero with err_o raised
// ---------------------------------------------------------------------------
module line_window_slice #(
    parameter int WORD_W   = line_window_pkg::WORD_W,
    parameter int LINE_W   = line_window_pkg::LINE_W,
    parameter int OFFSET_W = line_window_pkg::OFFSET_W
) (
    input  logic [LINE_W-1:0]   line_i,
    input  logic [OFFSET_W-1:0] offset_i,
    output logic [WORD_W-1:0]   window_o,
    output logic                err_o
);

    // Shifting two back-to-back copies of the line makes the circular case
    // fall out naturally; in-range offsets never reach the second copy.
    logic [WORD_W-1:0] rotated;
    assign rotated = WORD_W'({line_i, line_i} >> offset_i);

`ifdef LINE_WINDOW_WRAP_EN
    assign window_o = rotated;
    assign err_o    = 1'b0;
`else
    localparam logic [OFFSET_W-1:0] MAX_OFFSET = OFFSET_W'(LINE_W - WORD_W);

    logic outOfRange;
    assign outOfRange = (offset_i > MAX_OFFSET);
    assign window_o   = outOfRange ? '0 : rotated;
    assign err_o      = outOfRange;
`endif

endmodule

// File: rtl/line_window_fetch.sv
// ---------------------------------------------------------------------------
// line_window_fetch
// Collects LINE_WORDS upstream words into a line, then serves bit-granular
// WORD_W-bit window requests from that line until flushed.
// Ports:
//   sysclk    : clock, rising edge
//   reset     : asynchronous, active-low reset
//   wr_valid  : upstream word valid          wr_data : upstream word
//   wr_ready  : word accepted this cycle (FILL state)
//   flush     : drop the line and go back to filling (wins over wr/rd)
//   rd_valid  : window request valid          rd_offset : window start bit
//   rd_ready  : request accepted this cycle (SERVE state)
//   win_valid : one-cycle response pulse, one cycle after the request
//   win_data  : extracted window (holds last value between responses)
//   win_err   : request was out of range (only without LINE_WINDOW_WRAP_EN)
//   line_done : one-cycle pulse when the line becomes complete
// Macro LINE_WINDOW_WRAP_EN selects circular windows (see line_window_slice).
// ---------------------------------------------------------------------------
module line_window_fetch #(
    parameter int WORD_W     = line_window_pkg::WORD_W,
    parameter int LINE_WORDS = line_window_pkg::LINE_WORDS
) (
    input  logic                                  sysclk,
    input  logic                                  reset,
    input  logic                                  wr_valid,
    input  logic [WORD_W-1:0]                     wr_data,
    output logic                                  wr_ready,
    input  logic                                  flush,
    input  logic                                  rd_valid,
    input  logic [line_window_pkg::OFFSET_W-1:0]  rd_offset,
    output logic                                  rd_ready,
    output logic                                  win_valid,
    output logic [WORD_W-1:0]                     win_data,
    output logic                                  win_err,
    output logic                                  line_done
);

    import line_window_pkg::*;

    localparam int                LINE_BITS = WORD_W * LINE_WORDS;
    localparam int                COUNT_W   = $clog2(LINE_WORDS);
    localparam logic [COUNT_W-1:0] LAST_WORD = COUNT_W'(LINE_WORDS - 1);

    state_t                state_q;
    logic [COUNT_W-1:0]    count_q;
    logic [LINE_BITS-1:0]  line_q;
    logic                  winValid_q;
    logic [WORD_W-1:0]     winData_q;
    logic                  winErr_q;
    logic                  lineDone_q;

    logic [WORD_W-1:0]     sliceWindow;
    logic                  sliceErr;

    line_window_slice #(
        .WORD_W   (WORD_W),
        .LINE_W   (LINE_BITS),
        .OFFSET_W (OFFSET_W)
    ) u_slice (
        .line_i   (line_q),
        .offset_i (rd_offset),
        .window_o (sliceWindow),
        .err_o    (sliceErr)
    );

    // Handshake readiness follows directly from the registered state.
    assign wr_ready  = (state_q == FILL);
    assign rd_ready  = (state_q == SERVE);
    assign win_valid = winValid_q;
    assign win_data  = winData_q;
    assign win_err   = winErr_q;
    assign line_done = lineDone_q;

    // State machine, word counter, line storage and response registers.
    // Pulse outputs default low each cycle; win_data keeps its last value.
    // flush is checked first so a same-cycle word or request is dropped.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q    <= FILL;
            count_q    <= '0;
            line_q     <= '0;
            winValid_q <= 1'b0;
            winData_q  <= '0;
            winErr_q   <= 1'b0;
            lineDone_q <= 1'b0;
        end else begin
            winValid_q <= 1'b0;
            winErr_q   <= 1'b0;
            lineDone_q <= 1'b0;
            case (state_q)
                FILL: begin
                    if (flush) begin
                        count_q <= '0;
                    end else if (wr_valid) begin
                        line_q[count_q*WORD_W +: WORD_W] <= wr_data;
                        if (count_q == LAST_WORD) begin
                            count_q    <= '0;
                            state_q    <= SERVE;
                            lineDone_q <= 1'b1;
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                end
                SERVE: begin
                    if (flush) begin
                        state_q <= FILL;
                        count_q <= '0;
                    end else if (rd_valid) begin
                        winValid_q <= 1'b1;
                        winData_q  <= sliceWindow;
                        winErr_q   <= sliceErr;
                    end
                end
                default: begin
                    state_q <= FILL;
                    count_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_window_fetch.sv
// ---------------------------------------------------------------------------
// tb_line_window_fetch
// Directed bench for line_window_fetch. Inputs change on the falling edge
// and outputs are checked on the following falling edge, i.e. half a cycle
// after the rising edge that updated them.
// Honours LINE_WINDOW_WRAP_EN for the expected out-of-range responses.
// ---------------------------------------------------------------------------
module tb_line_window_fetch;

    logic        sysclk;
    logic        reset;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        flush;
    logic        rd_valid;
    logic [8:0]  rd_offset;
    logic        rd_ready;
    logic        win_valid;
    logic [31:0] win_data;
    logic        win_err;
    logic        line_done;

    int vectors;
    int miscompares;

    line_window_fetch dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .flush     (flush),
        .rd_valid  (rd_valid),
        .rd_offset (rd_offset),
        .rd_ready  (rd_ready),
        .win_valid (win_valid),
        .win_data  (win_data),
        .win_err   (win_err),
        .line_done (line_done)
    );

    // 10 ns clock.
    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Drive one cycle of inputs, let a rising edge pass, return mid-cycle.
    task automatic applyStimulus(input logic wv, input logic [31:0] wd,
                                 input logic rv, input logic [8:0] ro,
                                 input logic fl);
        wr_valid  = wv;
        wr_data   = wd;
        rd_valid  = rv;
        rd_offset = ro;
        flush     = fl;
        @(posedge sysclk);
        @(negedge sysclk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        wr_valid    = 1'b0;
        wr_data     = '0;
        flush       = 1'b0;
        rd_valid    = 1'b0;
        rd_offset   = '0;

        // Reset values while reset is held.
        @(negedge sysclk);
        @(negedge sysclk);
        checkOutput("rst_wr_ready",  32'(wr_ready),  32'd1);
        checkOutput("rst_rd_ready",  32'(rd_ready),  32'd0);
        checkOutput("rst_win_valid", 32'(win_valid), 32'd0);
        checkOutput("rst_win_data",  win_data,       32'h0);
        checkOutput("rst_win_err",   32'(win_err),   32'd0);
        checkOutput("rst_line_done", 32'(line_done), 32'd0);
        reset = 1'b1;
        @(negedge sysclk);

        // Fill words 0x1000_0000 + i.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 32'h1000_0000 + 32'(i), 1'b0, 9'd0, 1'b0);
            if (i == 14) begin
                checkOutput("fill14_wr_ready",  32'(wr_ready),  32'd1);
                checkOutput("fill14_line_done", 32'(line_done), 32'd0);
            end
        end
        checkOutput("fill_line_done", 32'(line_done), 32'd1);
        checkOutput("fill_wr_ready",  32'(wr_ready),  32'd0);
        checkOutput("fill_rd_ready",  32'(rd_ready),  32'd1);

        // A word offered in SERVE must be ignored.
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 9'd0, 1'b0);
        checkOutput("done_pulse_end", 32'(line_done), 32'd0);
        checkOutput("serve_wr_ready", 32'(wr_ready),  32'd0);

        // Back-to-back requests at offsets 0 and 16.
        applyStimulus(1'b0, 32'h0, 1'b1, 9'd0, 1'b0);
        checkOutput("off0_valid", 32'(win_valid), 32'd1);
        checkOutput("off0_data",  win_data,       32'h1000_0000);
        checkOutput("off0_err",   32'(win_err),   32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 9'd16, 1'b0);
        checkOutput("off16_valid", 32'(win_valid), 32'd1);
        checkOutput("off16_data",  win_data,       32'h0001_1000);
        checkOutput("off16_err",   32'(win_err),   32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 9'd0, 1'b0);
        checkOutput("idle_valid", 32'(win_valid), 32'd0);
        checkOutput("idle_hold",  win_data,       32'h0001_1000);

        // Last fully in-range offset.
        applyStimulus(1'b0, 32'h0, 1'b1, 9'd480, 1'b0);
        checkOutput("off480_data", win_data,     32'h1000_000F);
        checkOutput("off480_err",  32'(win_err), 32'd0);

        // First out-of-range offset and offset 496.
        applyStimulus(1'b0, 32'h0, 1'b1, 9'd481, 1'b0);
        checkOutput("off481_valid", 32'(win_valid), 32'd1);
`ifdef LINE_WINDOW_WRAP_EN
        checkOutput("off481_data", win_data,     32'h0800_0007);
        checkOutput("off481_err",  32'(win_err), 32'd0);
`else
        checkOutput("off481_data", win_data,     32'h0);
        checkOutput("off481_err",  32'(win_err), 32'd1);
`endif
        applyStimulus(1'b0, 32'h0, 1'b1, 9'd496, 1'b0);
`ifdef LINE_WINDOW_WRAP_EN
        checkOutput("off496_data", win_data,     32'h0000_1000);
        checkOutput("off496_err",  32'(win_err), 32'd0);
`else
        checkOutput("off496_data", win_data,     32'h0);
        checkOutput("off496_err",  32'(win_err), 32'd1);
`endif
        applyStimulus(1'b0, 32'h0, 1'b0, 9'd0, 1'b0);
        checkOutput("idle_err_low", 32'(win_err), 32'd0);

        // Flush with a simultaneous request: request dropped, back to FILL.
        applyStimulus(1'b0, 32'h0, 1'b1, 9'd0, 1'b1);
        checkOutput("flush_no_win",   32'(win_valid), 32'd0);
        checkOutput("flush_wr_ready", 32'(wr_ready),  32'd1);
        checkOutput("flush_rd_ready", 32'(rd_ready),  32'd0);

        // A request in FILL is ignored.
        applyStimulus(1'b0, 32'h0, 1'b1, 9'd0, 1'b0);
        checkOutput("fill_rd_ignored", 32'(win_valid), 32'd0);

        // Seven words, then asynchronous reset mid-cycle.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 32'h2000_0000 + 32'(i), 1'b0, 9'd0, 1'b0);
        end
        wr_valid = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        checkOutput("arst_wr_ready",  32'(wr_ready),  32'd1);
        checkOutput("arst_rd_ready",  32'(rd_ready),  32'd0);
        checkOutput("arst_win_valid", 32'(win_valid), 32'd0);
        checkOutput("arst_win_data",  win_data,       32'h0);
        checkOutput("arst_win_err",   32'(win_err),   32'd0);
        checkOutput("arst_line_done", 32'(line_done), 32'd0);
        @(negedge sysclk);
        reset = 1'b1;
        @(negedge sysclk);

        // After reset a full 16 words are needed again.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b1, 32'h3000_0000 + 32'(i), 1'b0, 9'd0, 1'b0);
        end
        checkOutput("refill15_wr_ready",  32'(wr_ready),  32'd1);
        checkOutput("refill15_rd_ready",  32'(rd_ready),  32'd0);
        checkOutput("refill15_line_done", 32'(line_done), 32'd0);
        applyStimulus(1'b1, 32'h3000_000F, 1'b0, 9'd0, 1'b0);
        checkOutput("refill16_line_done", 32'(line_done), 32'd1);
        checkOutput("refill16_rd_ready",  32'(rd_ready),  32'd1);

        // New line contents are served from the right word positions.
        applyStimulus(1'b0, 32'h0, 1'b1, 9'd0, 1'b0);
        checkOutput("new_off0_data", win_data, 32'h3000_0000);
        applyStimulus(1'b0, 32'h0, 1'b1, 9'd224, 1'b0);
        checkOutput("new_off224_data", win_data, 32'h3000_0007);
        applyStimulus(1'b0, 32'h0, 1'b1, 9'd4, 1'b0);
        checkOutput("new_off4_data", win_data, 32'h1300_0000);
        applyStimulus(1'b0, 32'h0, 1'b0, 9'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
